// File: rtl/shared_pkg.sv
// shared_pkg: common constants and skid-buffer state encoding for fifo_read_streamer.
//   FIFO_WIDTH    default data word width, must match the FIFO
//   skid_state_e  skid occupancy state; the encoding equals the occupancy count
package shared_pkg;
   localparam int FIFO_WIDTH = 16;
   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} skid_state_e;
endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: two-entry register buffer with head/tail pointers.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write din into the tail entry at the next edge
//   pop         retire the head entry at the next edge
//   dout        head entry; valid = occupancy != 0; occ = occupancy 0..2
module skid_buffer_2 import shared_pkg::*; #(
   parameter int W = shared_pkg::FIFO_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic [1:0]   occ
);
   skid_state_e state_q, state_d;
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic head_q, head_d, tail_q, tail_d;
   // simultaneous push and pop keeps the occupancy; push is never issued in S_TWO
   always_comb begin
      state_d = (push && !pop) ? (state_q == S_EMPTY ? S_ONE : S_TWO)
              : (pop && !push) ? (state_q == S_TWO ? S_ONE : S_EMPTY)
              : state_q;
      head_d = head_q ^ pop;
      tail_d = tail_q ^ push;
      mem_d = mem_q;
      if (push) mem_d[tail_q] = din;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_EMPTY;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         mem_q   <= mem_d;
      end
   end
   assign dout  = mem_q[head_q];
   assign valid = state_q != S_EMPTY;
   assign occ   = state_q;
endmodule

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: FIFO read master presenting words as a valid/ready stream.
//   clk, rst_n      clock, asynchronous active-low reset
//   drain_en        enables new FIFO reads
//   fifo_empty      FIFO empty flag; fifo_data_out valid the cycle after fifo_rd_en
//   fifo_underflow  FIFO underflow flag (used only with RD_STATS_EN)
//   fifo_rd_en      read strobe to the FIFO
//   m_data/m_valid/m_ready  output stream, driven from registered state only
//   rd_count, rd_err        delivered-word count and sticky read error (RD_STATS_EN only)
// Optional feature macro: RD_STATS_EN
module fifo_read_streamer #(
   parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
   parameter int SKID_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drain_en,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready
`ifdef RD_STATS_EN
   ,
   output logic [15:0]           rd_count,
   output logic                  rd_err
`endif
);
   if (SKID_DEPTH != 2) begin : g_bad_skid_depth
      $error("fifo_read_streamer: SKID_DEPTH must be 2");
   end
   logic       inflight_q, inflight_d, pop;
   logic [1:0] occ;
   logic [2:0] load;
   skid_buffer_2 #(.W(FIFO_WIDTH)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight_q),
      .pop   (pop),
      .din   (fifo_data_out),
      .dout  (m_data),
      .valid (m_valid),
      .occ   (occ)
   );
   // a read is a credit on a skid slot: buffered plus in-flight words, less the one
   // leaving this cycle, must stay below two; rst_n gating keeps rd_en low in reset
   always_comb begin
      pop        = m_valid & m_ready;
      load       = {1'b0, occ} + {2'b0, inflight_q};
      fifo_rd_en = rst_n & drain_en & ~fifo_empty & (load < 3'd2 + {2'b0, pop});
      inflight_d = fifo_rd_en;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_q <= 1'b0;
      else inflight_q <= inflight_d;
   end
`ifdef RD_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic        rd_err_q, rd_err_d;
   // underflow seen while a read is in flight means the FIFO was read while empty
   always_comb begin
      rd_count_d = rd_count_q + {15'b0, pop};
      rd_err_d   = rd_err_q | (inflight_q & fifo_underflow);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_count_q <= rd_count_d;
         rd_err_q   <= rd_err_d;
      end
   end
   assign rd_count = rd_count_q;
   assign rd_err   = rd_err_q;
`else
   logic unused_underflow;
   assign unused_underflow = fifo_underflow;
`endif
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: scoreboard bench; a queue-based FIFO model feeds the DUT and
// every word written to it is expected on the stream in the same order.
module tb_fifo_read_streamer;
   logic        clk, rst_n, drain_en, fifo_empty, fifo_underflow, m_ready;
   logic [15:0] fifo_data_out, m_data;
   logic        fifo_rd_en, m_valid;
`ifdef RD_STATS_EN
   logic [15:0] rd_count;
   logic        rd_err;
`endif
   fifo_read_streamer #(.FIFO_WIDTH(16), .SKID_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .drain_en       (drain_en),
      .fifo_empty     (fifo_empty),
      .fifo_data_out  (fifo_data_out),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready)
`ifdef RD_STATS_EN
      ,
      .rd_count       (rd_count),
      .rd_err         (rd_err)
`endif
   );
   logic [15:0] fq[$];
   logic [15:0] exp_q[$];
   int n_cmp = 0, n_bad = 0;
   int rd_pulses = 0, beats = 0, pushed = 0;
   int rd0, b0, first_rd, first_mv, last_mvk;
   logic last_rd, last_mv;
   logic hold_v = 1'b0;
   logic [15:0] hold_d = '0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic push_word(input logic [15:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask
   // one clock: sample at negedge, then model the FIFO's registered read after the edge
   task automatic step();
      @(negedge clk);
      last_rd = fifo_rd_en;
      last_mv = m_valid;
      check("rd_en_while_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
      if (last_rd) rd_pulses++;
      if (m_valid && m_ready) beats++;
      @(posedge clk);
      #1;
      fifo_underflow = last_rd && fq.size() == 0;
      if (last_rd && fq.size() != 0) fifo_data_out = fq.pop_front();
      fifo_empty = fq.size() == 0;
   endtask
   initial forever begin
      @(negedge clk);
      if (!rst_n) hold_v = 1'b0;
      else begin
         if (hold_v) check("held_while_stalled", {15'b0, m_valid, m_data}, {15'b0, 1'b1, hold_d});
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", {31'b0, m_valid}, 32'd0);
            else check("stream_order", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
         end
         hold_v = m_valid && !m_ready;
         hold_d = m_data;
      end
   end
   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n = 1'b1; drain_en = 1'b0; fifo_empty = 1'b1; fifo_underflow = 1'b0;
      m_ready = 1'b0; fifo_data_out = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_m_valid", {31'b0, m_valid}, 32'd0);
      check("reset_m_data", {16'b0, m_data}, 32'd0);
      check("reset_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
`ifdef RD_STATS_EN
      m_ready = 1'b1; drain_en = 1'b1;
      for (int i = 0; i < 5; i++) push_word(16'h0100 + 16'(i));
      repeat (12) step();
      check("stats_rd_count", {16'b0, rd_count}, 32'd5);
      check("stats_rd_err_clear", {31'b0, rd_err}, 32'd0);
      push_word(16'hABCD);
      for (int i = 0; i < 5; i++) begin
         step();
         if (last_rd) break;
      end
      fifo_underflow = 1'b1;
      step();
      check("stats_rd_err_set", {31'b0, rd_err}, 32'd1);
      repeat (4) step();
      check("stats_rd_err_sticky", {31'b0, rd_err}, 32'd1);
`endif
      // reset while words are buffered and one is in flight
      m_ready = 1'b0; drain_en = 1'b1;
      for (int i = 0; i < 8; i++) push_word(16'h0200 + 16'(i));
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      check("midreset_m_valid", {31'b0, m_valid}, 32'd0);
      check("midreset_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("midreset_m_data", {16'b0, m_data}, 32'd0);
`ifdef RD_STATS_EN
      check("midreset_rd_count", {16'b0, rd_count}, 32'd0);
      check("midreset_rd_err", {31'b0, rd_err}, 32'd0);
`endif
      fq.delete(); exp_q.delete(); fifo_empty = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      m_ready = 1'b1;
      b0 = beats;
      repeat (10) step();
      check("post_reset_beats", beats - b0, 32'd0);
      check("post_reset_m_valid", {31'b0, m_valid}, 32'd0);
      // full-rate streaming of 8 words
      first_rd = -1; first_mv = -1; last_mvk = -1;
      rd0 = rd_pulses; b0 = beats;
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      for (int k = 0; k < 30; k++) begin
         step();
         if (last_rd && first_rd < 0) first_rd = k;
         if (last_mv && first_mv < 0) first_mv = k;
         if (last_mv) last_mvk = k;
      end
      check("stream_latency", first_mv - first_rd, 32'd2);
      check("stream_back_to_back", last_mvk - first_mv, 32'd7);
      check("stream_beats", beats - b0, 32'd8);
      check("stream_rd_pulses", rd_pulses - rd0, 32'd8);
      check("stream_drained", exp_q.size(), 32'd0);
      // backpressure: only two words may be pulled out of the FIFO
      m_ready = 1'b0;
      rd0 = rd_pulses;
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      repeat (10) step();
      check("bp_rd_pulses", rd_pulses - rd0, 32'd2);
      check("bp_m_valid", {31'b0, m_valid}, 32'd1);
      check("bp_head", {16'b0, m_data}, 32'h0001);
      m_ready = 1'b1;
      repeat (20) step();
      check("bp_drained", exp_q.size(), 32'd0);
      check("bp_fifo_empty", fq.size(), 32'd0);
      // drain_en drops right after a read
      for (int i = 0; i < 4; i++) push_word(16'h0010 + 16'(i));
      step();
      check("drain_first_rd", {31'b0, last_rd}, 32'd1);
      drain_en = 1'b0;
      rd0 = rd_pulses; b0 = beats;
      repeat (8) step();
      check("drain_no_rd", rd_pulses - rd0, 32'd0);
      check("drain_inflight_delivered", beats - b0, 32'd1);
      check("drain_fifo_left", fq.size(), 32'd3);
      drain_en = 1'b1;
      repeat (15) step();
      check("drain_resumed", exp_q.size(), 32'd0);
      // random data, alternating ready, random drain_en
      for (int c = 0; c < 60000 && (pushed < 10000 || exp_q.size() != 0); c++) begin
         m_ready = c[0];
         drain_en = ($urandom_range(0, 9) != 0) || pushed >= 10000;
         step();
         if (pushed < 10000 && fq.size() < 6 && $urandom_range(0, 2) != 0) begin
            push_word(16'($urandom));
            pushed++;
         end
      end
      check("random_all_delivered", exp_q.size() + (10000 - pushed), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
